// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide run on magnitudes; signs are applied in FIX.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            qsign;
  logic            rsign;
  logic [WIDTH-1:0] opnd;
  // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
  logic [PW-1:0]   prod;

  logic            a_neg;
  logic            b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [PW-1:0]    mul_nxt;
  logic [PW-1:0]    div_nxt;
  logic [PW-1:0]    fix_res;
  logic [WIDTH-1:0] hi_part;
  logic [WIDTH-1:0] lo_part;

  // Operand magnitudes; op[0]=1 marks the unsigned variants.
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? WIDTH'(~a + WIDTH'(1)) : a;
    b_mag = b_neg ? WIDTH'(~b + WIDTH'(1)) : b;
  end

  // One iteration of each algorithm plus the final sign correction.
  always_comb begin
    msum    = {1'b0, prod[PW-1:WIDTH]} + {1'b0, (prod[0] ? opnd : '0)};
    mul_nxt = {msum, prod[WIDTH-1:1]};

    shifted = {prod[PW-1:WIDTH], prod[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    rem_nxt = ge ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
    div_nxt = {rem_nxt, prod[WIDTH-2:0], ge};

    hi_part = prod[PW-1:WIDTH];
    lo_part = prod[WIDTH-1:0];
    if (is_div) begin
      fix_res = {(rsign ? WIDTH'(~hi_part + WIDTH'(1)) : hi_part),
                 (qsign ? WIDTH'(~lo_part + WIDTH'(1)) : lo_part)};
    end else begin
      fix_res = qsign ? PW'(~prod + PW'(1)) : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            // Divide by zero keeps the quotient at all-ones; the remainder
            // re-signs to the original dividend.
            qsign  <= (op[1] && (b == '0)) ? 1'b0 : (a_neg ^ b_neg);
            rsign  <= a_neg;
            opnd   <= op[1] ? b_mag : a_mag;
            prod   <= op[1] ? {WIDTH'(0), a_mag} : {WIDTH'(0), b_mag};
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        CALC: begin
          prod <= is_div ? div_nxt : mul_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_res[PW-1:WIDTH];
          lo    <= fix_res[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic HI/LO model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, expv);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy;
    int qi, ri;
    logic [31:0] qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        qv = 32'(qi);
        rv = 32'(ri);
        return {rv, qv};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called #1 after an edge; returns #1 after the edge where done rises.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit disturb);
    logic [63:0] res;
    int cyc;
    int bcnt;
    res   = ref_model(o, x, y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("hi_held", hi, exp_hi);
    check("lo_held", lo, exp_lo);
    cyc  = 0;
    bcnt = 1;
    while (!done && cyc < 100) begin
      if (disturb && cyc == 10) begin
        start   = 1'b1;
        wr_hi   = 1'b1;
        wr_data = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      wr_hi = 1'b0;
      cyc++;
      if (busy) bcnt++;
      if (disturb && cyc == 11) check("hi_held_busy", hi, exp_hi);
    end
    check("done_latency", 32'(cyc), 32'd33);
    check("busy_cycles", 32'(bcnt), 32'd33);
    check("busy_clear", 32'(busy), 32'd0);
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
  endtask

  task automatic mt_write(input bit whi, input bit wlo, input logic [31:0] d);
    wr_hi   = whi;
    wr_lo   = wlo;
    wr_data = d;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    if (whi) exp_hi = d;
    if (wlo) exp_lo = d;
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
    check("mt_no_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    mt_write(1'b1, 1'b0, 32'hAAAA_0000);
    mt_write(1'b0, 1'b1, 32'h0000_5555);
    run_op(2'd1, 32'd3, 32'd5, 1'b1);
    idle_cycle();
    mt_write(1'b1, 1'b1, 32'h1234_5678);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
    idle_cycle();

    // start wins over same-cycle MT writes
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    run_op(2'd3, 32'd1000, 32'd33, 1'b0);
    idle_cycle();

    // reset mid-operation aborts without touching HI/LO beyond clearing
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    run_op(2'd1, 32'd2, 32'd2, 1'b0);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom), 1'($urandom), 32'($urandom));
      run_op(2'($urandom), pick(), pick(), 1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
